mc_r_cpu: RTL
=============

# mc_r_cpu

Multi-cycle, parametrised successor to the single-cycle R-type processor. It executes MIPS R-type instructions from an internal, writable instruction memory through a four-state FETCH/DECODE/EXEC/WB controller. It keeps the `ALU_F`/`zf`/`of` observation outputs, now registered, and adds shifts, `slt`, run/stop control, an instruction-load port and retire/illegal status. It is the top-level CPU core for the R-type lab builds.

## Interface
Parameters:
- `DATA_W`, default 32: datapath and register width; legal range 8..32.
- `IMEM_DEPTH`, default 64: instruction words; must be a power of two, at least 2.
- `PC_W`, default clog2(`IMEM_DEPTH`): program counter width (derived).

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `run`, in, 1: start/continue execution; sampled only in FETCH.
- `imem_we`, in, 1: instruction-memory write enable.
- `imem_waddr`, in, `PC_W`: instruction write address.
- `imem_wdata`, in, 32: instruction word to write.
- `ALU_F`, out, `DATA_W`: registered ALU result.
- `zf`, out, 1: registered zero flag, 1 when `ALU_F` == 0.
- `of`, out, 1: registered signed-overflow flag.
- `pc`, out, `PC_W`: address of the instruction in flight, or the next instruction when idle.
- `retire`, out, 1: one-cycle pulse in WB.
- `illegal`, out, 1: one-cycle pulse in WB, only when the retired instruction was illegal.

## Operation
- Instruction format: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- Only op == 0 is legal. Legal funct codes:
  - add 100000, sub 100010: two's-complement, `DATA_W` bits, carry-out discarded.
  - and 100100, or 100101, xor 100110, nor 100111: bitwise.
  - slt 101010: signed compare, result 1 or 0, zero-extended.
  - sll 000000, srl 000010: shift rt by shamt, logical fill.
- Any other op or funct is illegal and executes as a NOP:
  - no register write;
  - `ALU_F`, `zf` and `of` hold their previous values;
  - `illegal` pulses together with `retire`.
- `of` is set only on signed overflow of add or sub; it is 0 for every other legal op.
- Shift rules: a shift with shamt ≥ `DATA_W` produces 0; shamt 0 passes rt through unchanged.
- Register file: 32 × `DATA_W`, two asynchronous read ports, one synchronous write port.
  - r0 always reads 0; writes with rd == 0 are discarded.
  - All registers clear to 0 on `rst`.
- Instruction memory: `IMEM_DEPTH` × 32, synchronous write.
  - Writes are accepted in any state.
  - When the written address is fetched in the same cycle, FETCH reads the old word.
- Controller states, one cycle each:
  - FETCH: if `run`=1, IR <= imem[pc] and go to DECODE; otherwise stay in FETCH with pc held.
  - DECODE: A <= reg[rs]; B <= reg[rt]; decode the ALU operation and the legal bit.
  - EXEC: if legal, `ALU_F`, `zf` and `of` <= ALU outputs.
  - WB: if legal and rd != 0, reg[rd] <= `ALU_F`. pc <= pc + 1, wrapping from `IMEM_DEPTH`−1 to 0. Pulse `retire`, and `illegal` if the instruction was illegal. Return to FETCH.
- `run` falling mid-instruction does not abort it; the instruction completes and the core stops in FETCH.
- Reset values:
  - state FETCH; pc 0; IR 0; A and B 0;
  - `ALU_F` 0, `zf` 1, `of` 0, `retire` 0, `illegal` 0;
  - all registers 0; instruction-memory contents are not reset.
- `rst` asserted in any state aborts the instruction in flight: no register write and no retire.

## Timing
- Each instruction takes exactly 4 cycles from the FETCH edge to the WB edge.
- With `run` held at 1, the core sustains one retire every 4 cycles.
- `ALU_F`, `zf` and `of` change only on the EXEC edge, which is one cycle before the matching `retire` pulse.
- A register written in WB is visible to the next instruction's DECODE; no forwarding or hazard logic is needed.
- `pc` increments on the same edge that `retire` asserts.
- First fetch after `rst` deasserts with `run`=1: `retire` asserts 4 edges later.

## Test plan
- Reset, then hold `run`=0 for 10 cycles -> pc=0, `retire` never pulses, `ALU_F`=0, `zf`=1, `of`=0.
- Load nor r1,r0,r0; sub r2,r0,r1; add r3,r2,r2 (`DATA_W`=32), then run -> `ALU_F` reads 0xFFFFFFFF, then 0x00000001, then 0x00000002. `retire` pulses at cycles 4, 8 and 12. `of`=0 throughout.
- Continue with srl r4,r1,1 (shamt 1); add r5,r4,r2 -> `ALU_F`=0x7FFFFFFF with `of`=0, then 0x80000000 with `of`=1 and `zf`=0.
- sub r6,r2,r2; slt r7,r1,r2 -> first `ALU_F`=0 with `zf`=1, then `ALU_F`=1 (−1 < 1).
- Load word 0xFC000000 (op≠0), then add r0,r1,r1 -> the first pulses `illegal` with `retire` and leaves `ALU_F` unchanged. The second drives `ALU_F`=0xFFFFFFFE, but r0 still reads 0 when checked by a later add r8,r0,r0 (`ALU_F`=0).
- `IMEM_DEPTH`=4, run 4 instructions -> pc wraps 3→0. Assert `rst` during EXEC of the 5th instruction -> no `retire`, pc=0, registers cleared.

Source files
------------

// File: rtl/mc_r_cpu.sv
// Multi-cycle MIPS R-type core: FETCH/DECODE/EXEC/WB controller, writable
// instruction memory, 32-entry register file and registered ALU flags.
module mc_r_cpu #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [DATA_W-1:0] ALU_F,
  output logic              zf,
  output logic              of,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLL,
    OP_SRL
  } alu_op_t;

  localparam logic [5:0] DATA_W6 = 6'(DATA_W);

  state_t            state, state_nxt;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q;
  alu_op_t           op_q, dec_op;
  logic              legal_q, dec_legal;

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       imem [IMEM_DEPTH];

  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        opcode, funct;
  logic [DATA_W-1:0] rs_val, rt_val;

  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              add_of, sub_of, slt_bit, shift_big, alu_of;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its peers, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through this block leaves state_nxt
    // unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      S_FETCH:  if (run) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decode: only op 0 with one of the listed funct codes is legal
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_op    = OP_ADD;
    dec_legal = 1'b0;
    if (opcode == 6'd0) begin
      dec_legal = 1'b1;
      case (funct)
        6'b100000: dec_op = OP_ADD;
        6'b100010: dec_op = OP_SUB;
        6'b100100: dec_op = OP_AND;
        6'b100101: dec_op = OP_OR;
        6'b100110: dec_op = OP_XOR;
        6'b100111: dec_op = OP_NOR;
        6'b101010: dec_op = OP_SLT;
        6'b000000: dec_op = OP_SLL;
        6'b000010: dec_op = OP_SRL;
        default:   dec_legal = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign sum       = a_q + b_q;
  assign diff      = a_q - b_q;
  assign add_of    = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1]  != a_q[DATA_W-1]);
  assign sub_of    = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
  assign slt_bit   = $signed(a_q) < $signed(b_q);
  // shamt is 5 bits, so narrow datapaths can see shifts past their width
  assign shift_big = ({1'b0, shamt} >= DATA_W6);

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum;  alu_of = add_of; end
      OP_SUB: begin alu_res = diff; alu_of = sub_of; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
      OP_SLL: alu_res = shift_big ? '0 : (b_q << shamt);
      OP_SRL: alu_res = shift_big ? '0 : (b_q >> shamt);
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file: r0 is hard-wired to zero on read
  // ---------------------------------------------------------------------------
  assign rs_val = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? '0 : regs[rt];

  // NOTE: the register file is architecturally cleared by rst, so it lives in
  // the async-reset process; the instruction memory below has no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == S_WB && legal_q && rd != 5'd0) begin
      regs[rd] <= ALU_F;
    end
  end

  // A write to the address being fetched lands after FETCH samples the old word
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      legal_q <= 1'b0;
      ALU_F   <= '0;
      zf      <= 1'b1;
      of      <= 1'b0;
      pc      <= '0;
      retire  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_FETCH: begin
          if (run) ir <= imem[pc];
        end
        S_DECODE: begin
          a_q     <= rs_val;
          b_q     <= rt_val;
          op_q    <= dec_op;
          legal_q <= dec_legal;
        end
        S_EXEC: begin
          if (legal_q) begin
            ALU_F <= alu_res;
            zf    <= (alu_res == '0);
            of    <= alu_of;
          end
        end
        S_WB: begin
          pc      <= pc + PC_W'(1);
          retire  <= 1'b1;
          illegal <= ~legal_q;
        end
        default: ;
      endcase
    end
  end

endmodule
